scc_8lc_decode_ctrl: RTL and testbench

//  Pipelined decode controller for the SCC 8LC 72-bit codeword (64 data + 8 check).
//  - Accepts codeword + precomputed 8-bit syndrome over valid/ready.
//  - Drives the syndrome into the external errorinfo lookup (combinational).
//  - Applies the bit flips, emits corrected data plus CE/DUE status.
//  - Keeps saturating error statistics and a threshold-alert state machine for the scrub/RAS layer.

---
 rtl/scc_8lc_decode_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_scc_8lc_decode_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_8lc_decode_ctrl.sv
// SCC 8LC decode controller: two-stage elastic pipeline that drives the
// external errorinfo lookup, applies the bit flips it reports, and keeps
// saturating CE/DUE statistics with a threshold alert FSM.
module scc_8lc_decode_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CE_THRESH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [71:0]      in_cw,
  input  logic [7:0]       in_syn,
  output logic [7:0]       lk_syn,
  input  logic [2:0]       lk_type,
  input  logic [6:0]       lk_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_ce,
  output logic             out_due,
  output logic [2:0]       out_type,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] ce_cnt,
  output logic [CNT_W-1:0] due_cnt,
  output logic             alert
);

  localparam int unsigned CW_W   = 72;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned SYN_W  = 8;
  localparam int unsigned POS_W  = 8;
  localparam logic [POS_W-1:0] MAX_POS = POS_W'(CW_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CE_LIM  = CNT_W'(CE_THRESH);

  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_SE   = 3'b001;
  localparam logic [2:0] T_DAE  = 3'b010;
  localparam logic [2:0] T_DE   = 3'b011;
  localparam logic [2:0] T_TE   = 3'b100;
  localparam logic [2:0] T_DUE  = 3'b111;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_ALERT  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ce;
    logic              due;
    logic [2:0]        typ;
  } res_t;

  // pipeline registers
  logic              r_s1_valid;
  logic [CW_W-1:0]   r_s1_cw;
  logic [SYN_W-1:0]  r_s1_syn;
  logic              r_s2_valid;
  res_t              r_s2;

  // statistics / FSM registers
  logic [CNT_W-1:0]  r_ce_cnt;
  logic [CNT_W-1:0]  r_due_cnt;
  state_t            r_state;
  logic              r_alert;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic [POS_W-1:0]  w_p0;
  logic [POS_W-1:0]  w_p1;
  logic [POS_W-1:0]  w_p2;
  logic              w_use0;
  logic              w_use1;
  logic              w_use2;
  logic              w_defined;
  logic              w_oob;
  logic [CW_W-1:0]   w_mask;
  logic [CW_W-1:0]   w_corr;
  res_t              w_res;
  logic              w_unused_chk;
  logic              w_deliver;
  logic              w_ce_inc;
  logic              w_due_inc;
  logic [CNT_W-1:0]  w_ce_nxt;
  logic [CNT_W-1:0]  w_due_nxt;
  state_t            w_state_nxt;

  // Elastic handshake: a stage may load when it is empty or its content leaves.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;
  assign lk_syn   = r_s1_syn;

  // Stage 1: capture codeword and syndrome on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= '0;
      r_s1_syn   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_cw  <= in_cw;
        r_s1_syn <= in_syn;
      end
    end
  end

  // Decode the lookup result into a flip mask and CE/DUE status.
  always_comb begin
    w_p0      = {1'b0, lk_addr};
    w_p1      = w_p0 + POS_W'(1);
    w_p2      = w_p0 + POS_W'(2);
    w_use0    = 1'b0;
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_defined = 1'b1;
    w_mask    = '0;
    w_res     = '0;
    case (lk_type)
      T_NONE: ;
      T_SE:   w_use0 = 1'b1;
      T_DAE:  begin w_use0 = 1'b1; w_use1 = 1'b1; end
      T_DE:   begin w_use0 = 1'b1; w_use2 = 1'b1; end
      T_TE:   begin w_use0 = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
      default: w_defined = 1'b0;
    endcase
    // a position past the codeword means the lookup is inconsistent: refuse to flip
    w_oob = (w_use0 && (w_p0 > MAX_POS)) ||
            (w_use1 && (w_p1 > MAX_POS)) ||
            (w_use2 && (w_p2 > MAX_POS));
    if (!w_defined || w_oob) begin
      // out_type reports DUE for anything the controller declined to correct
      w_res.due = 1'b1;
      w_res.typ = T_DUE;
    end else begin
      if (w_use0) w_mask = w_mask | (CW_W'(1) << w_p0);
      if (w_use1) w_mask = w_mask | (CW_W'(1) << w_p1);
      if (w_use2) w_mask = w_mask | (CW_W'(1) << w_p2);
      w_res.ce  = w_use0;
      w_res.typ = lk_type;
    end
    w_corr     = r_s1_cw ^ w_mask;
    w_res.data = w_corr[DATA_W-1:0];
  end

  // corrected check bits are not part of the delivered data
  assign w_unused_chk = ^w_corr[CW_W-1:DATA_W];

  // Stage 2: register corrected word and status; hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2 <= w_res;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2.data;
  assign out_ce    = r_s2.ce;
  assign out_due   = r_s2.due;
  assign out_type  = r_s2.typ;

  assign w_deliver = r_s2_valid && out_ready;
  assign w_ce_inc  = w_deliver && r_s2.ce;
  assign w_due_inc = w_deliver && r_s2.due;

  // Saturating counter next values; clear wins over a same-cycle increment.
  always_comb begin
    w_ce_nxt  = r_ce_cnt;
    w_due_nxt = r_due_cnt;
    if (stat_clr) begin
      w_ce_nxt  = '0;
      w_due_nxt = '0;
    end else begin
      if (w_ce_inc && (r_ce_cnt != CNT_MAX))   w_ce_nxt  = r_ce_cnt + CNT_W'(1);
      if (w_due_inc && (r_due_cnt != CNT_MAX)) w_due_nxt = r_due_cnt + CNT_W'(1);
    end
  end

  // Alert FSM next state: enter on CE threshold or any delivered DUE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: if ((w_ce_inc && (w_ce_nxt >= CE_LIM)) || w_due_inc) w_state_nxt = ST_ALERT;
      ST_ALERT:  w_state_nxt = ST_ALERT;
      default:   w_state_nxt = ST_NORMAL;
    endcase
    if (stat_clr) w_state_nxt = ST_NORMAL;
  end

  // Statistics and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce_cnt  <= '0;
      r_due_cnt <= '0;
      r_state   <= ST_NORMAL;
      r_alert   <= 1'b0;
    end else begin
      r_ce_cnt  <= w_ce_nxt;
      r_due_cnt <= w_due_nxt;
      r_state   <= w_state_nxt;
      r_alert   <= (w_state_nxt == ST_ALERT);
    end
  end

  assign ce_cnt  = r_ce_cnt;
  assign due_cnt = r_due_cnt;
  assign alert   = r_alert;

endmodule

// File: tb/tb_scc_8lc_decode_ctrl.sv
// Bench for scc_8lc_decode_ctrl: two instances (wide counters / threshold 4,
// 2-bit counters / threshold 3) share stimulus and are compared against a
// FIFO-level reference model of the decode pipeline.
module tb_scc_8lc_decode_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, stat_clr;
  logic [71:0] in_cw;
  logic [7:0]  in_syn;

  logic        a_in_ready, a_out_valid, a_out_ce, a_out_due, a_alert;
  logic [7:0]  a_lk_syn;
  logic [2:0]  a_lk_type, a_out_type;
  logic [6:0]  a_lk_addr;
  logic [63:0] a_out_data;
  logic [15:0] a_ce_cnt, a_due_cnt;

  logic        b_in_ready, b_out_valid, b_out_ce, b_out_due, b_alert;
  logic [7:0]  b_lk_syn;
  logic [2:0]  b_lk_type, b_out_type;
  logic [6:0]  b_lk_addr;
  logic [63:0] b_out_data;
  logic [1:0]  b_ce_cnt, b_due_cnt;

  // errorinfo lookup table, indexed by syndrome
  logic [2:0] tab_type [256];
  logic [6:0] tab_addr [256];
  assign a_lk_type = tab_type[a_lk_syn];
  assign a_lk_addr = tab_addr[a_lk_syn];
  assign b_lk_type = tab_type[b_lk_syn];
  assign b_lk_addr = tab_addr[b_lk_syn];

  scc_8lc_decode_ctrl #(.CNT_W(16), .CE_THRESH(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_cw(in_cw), .in_syn(in_syn), .lk_syn(a_lk_syn), .lk_type(a_lk_type),
    .lk_addr(a_lk_addr), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ce(a_out_ce), .out_due(a_out_due),
    .out_type(a_out_type), .stat_clr(stat_clr), .ce_cnt(a_ce_cnt),
    .due_cnt(a_due_cnt), .alert(a_alert));

  scc_8lc_decode_ctrl #(.CNT_W(2), .CE_THRESH(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_cw(in_cw), .in_syn(in_syn), .lk_syn(b_lk_syn), .lk_type(b_lk_type),
    .lk_addr(b_lk_addr), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ce(b_out_ce), .out_due(b_out_due),
    .out_type(b_out_type), .stat_clr(stat_clr), .ce_cnt(b_ce_cnt),
    .due_cnt(b_due_cnt), .alert(b_alert));

  typedef struct {
    logic [63:0] data;
    logic        ce;
    logic        due;
    logic [2:0]  typ;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          m_ce = 0, m_due = 0;
  bit          m_alert_a = 0, m_alert_b = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [71:0] stim_cw[$];
  logic [7:0]  stim_syn[$];

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [71:0] rnd72();
    return 72'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Expected result from the error-type rules: flip the listed positions unless undefined or off the end.
  function automatic exp_t predict(input logic [71:0] cw, input logic [7:0] syn);
    exp_t e;
    int a, np, top;
    logic [71:0] w;
    logic [2:0] t;
    t = tab_type[syn];
    a = int'(tab_addr[syn]);
    w = cw;
    case (t)
      3'd1:      np = 1;
      3'd2, 3'd3: np = 2;
      3'd4:      np = 3;
      default:   np = 0;
    endcase
    top = (t == 3'd3) ? a + 2 : a + np - 1;
    e.ce = 1'b0; e.due = 1'b0; e.typ = t; e.acc = 0;
    if (t != 3'd0) begin
      if (np == 0 || top > 71) begin
        e.due = 1'b1;
        e.typ = 3'b111;
      end else begin
        for (int i = 0; i < np; i++) begin
          int p;
          p = (t == 3'd3 && i == 1) ? a + 2 : a + i;
          w[p] = ~w[p];
        end
        e.ce = 1'b1;
      end
    end
    e.data = w[63:0];
    return e;
  endfunction

  // Front word is visible once it has spent one edge in the first stage.
  function automatic bit exp_ov();
    return (q.size() > 0) && (cyc >= q[0].acc + 1);
  endfunction

  // Reference model: words in flight form a 2-deep FIFO; statistics follow deliveries.
  always @(posedge clk) begin : model
    bit   dlv, acc;
    exp_t e;
    if (rst) begin
      q.delete();
      m_ce = 0; m_due = 0; m_alert_a = 0; m_alert_b = 0;
      cyc++;
    end else begin
      dlv = exp_ov() && out_ready;
      acc = in_valid && ((q.size() < 2) || out_ready);
      if (dlv) begin
        e = q.pop_front();
        m_ce  += int'(e.ce);
        m_due += int'(e.due);
        if (e.due || sat(m_ce, 16) >= 4) m_alert_a = 1;
        if (e.due || sat(m_ce, 2) >= 3)  m_alert_b = 1;
      end
      if (stat_clr) begin
        m_ce = 0; m_due = 0; m_alert_a = 0; m_alert_b = 0;
      end
      cyc++;
      if (acc) begin
        e = predict(in_cw, in_syn);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; stat_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Stream the queued stimulus through both DUTs, comparing every cycle with the model.
  task automatic test_stream(input string name, input int ready_mode, input int clr_pct);
    int   idx = 0;
    int   budget = 0;
    bit   e_ir, e_ov;
    exp_t e;
    while (budget < 3000) begin
      @(negedge clk);
      if (idx >= stim_cw.size() && q.size() == 0) break;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (budget % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      stat_clr = (clr_pct != 0) && ($urandom_range(0, 99) < clr_pct);
      in_valid = (idx < stim_cw.size());
      if (in_valid) begin
        in_cw  = stim_cw[idx];
        in_syn = stim_syn[idx];
      end
      #1;
      e_ir = (q.size() < 2) || out_ready;
      e_ov = exp_ov();
      n_cmp++;
      if ({a_in_ready, b_in_ready} !== {e_ir, e_ir}) begin
        n_bad++;
        $display("FAIL %s in_ready: got a=%b b=%b want %b", name, a_in_ready, b_in_ready, e_ir);
      end
      n_cmp++;
      if ({a_out_valid, b_out_valid} !== {e_ov, e_ov}) begin
        n_bad++;
        $display("FAIL %s out_valid: got a=%b b=%b want %b", name, a_out_valid, b_out_valid, e_ov);
      end
      if (e_ov) begin
        e = q[0];
        n_cmp++;
        if (a_out_data !== e.data || b_out_data !== e.data ||
            {a_out_ce, a_out_due, a_out_type} !== {e.ce, e.due, e.typ} ||
            {b_out_ce, b_out_due, b_out_type} !== {e.ce, e.due, e.typ}) begin
          n_bad++;
          $display("FAIL %s word: got a=%h/%b%b/%b b=%h/%b%b/%b want %h/%b%b/%b", name,
                   a_out_data, a_out_ce, a_out_due, a_out_type,
                   b_out_data, b_out_ce, b_out_due, b_out_type,
                   e.data, e.ce, e.due, e.typ);
        end
      end
      n_cmp++;
      if (a_ce_cnt !== 16'(sat(m_ce, 16)) || a_due_cnt !== 16'(sat(m_due, 16))) begin
        n_bad++;
        $display("FAIL %s a_counters: got ce=%0d due=%0d want ce=%0d due=%0d", name,
                 a_ce_cnt, a_due_cnt, sat(m_ce, 16), sat(m_due, 16));
      end
      n_cmp++;
      if (b_ce_cnt !== 2'(sat(m_ce, 2)) || b_due_cnt !== 2'(sat(m_due, 2))) begin
        n_bad++;
        $display("FAIL %s b_counters: got ce=%0d due=%0d want ce=%0d due=%0d", name,
                 b_ce_cnt, b_due_cnt, sat(m_ce, 2), sat(m_due, 2));
      end
      n_cmp++;
      if ({a_alert, b_alert} !== {m_alert_a, m_alert_b}) begin
        n_bad++;
        $display("FAIL %s alert: got a=%b b=%b want a=%b b=%b", name, a_alert, b_alert, m_alert_a, m_alert_b);
      end
      if (in_valid && e_ir) idx++;
      budget++;
    end
    if (budget >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: got %0d words left want 0", name, q.size());
    end
    in_valid = 1'b0; stat_clr = 1'b0;
    stim_cw.delete(); stim_syn.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
    in_cw = '0; in_syn = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out_ce, a_out_due, a_out_type, a_out_data, a_alert} !== '0 ||
        {b_out_valid, b_out_ce, b_out_due, b_out_type, b_out_data, b_alert} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got a=%b%b%b/%h b=%b%b%b/%h want all zero",
               a_out_valid, a_out_ce, a_out_due, a_out_data, b_out_valid, b_out_ce, b_out_due, b_out_data);
    end
    n_cmp++;
    if ({a_ce_cnt, a_due_cnt, b_ce_cnt, b_due_cnt} !== '0 || {a_in_ready, b_in_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_cnt_ready: got a=%0d/%0d/%b b=%0d/%0d/%b want 0/0/1",
               a_ce_cnt, a_due_cnt, a_in_ready, b_ce_cnt, b_due_cnt, b_in_ready);
    end
  endtask

  task automatic test_clean();
    logic [71:0] cw;
    do_reset();
    cw = rnd72();
    @(negedge clk);
    in_cw = cw; in_syn = 8'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (a_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_early: got out_valid=%b want 0", a_out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_data !== cw[63:0] || {a_out_ce, a_out_due} !== 2'b00) begin
      n_bad++;
      $display("FAIL clean_word: got v=%b d=%h ce=%b due=%b want v=1 d=%h ce=0 due=0",
               a_out_valid, a_out_data, a_out_ce, a_out_due, cw[63:0]);
    end
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_ce_cnt !== 16'd0 || a_due_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL clean_after: got v=%b ce=%0d due=%0d want 0 0 0", a_out_valid, a_ce_cnt, a_due_cnt);
    end
  endtask

  task automatic test_single_dae();
    logic [71:0] g;
    do_reset();
    g = rnd72();
    stim_cw.push_back(g ^ (72'(1) << 5));  stim_syn.push_back(8'd1);
    g = rnd72();
    stim_cw.push_back(g ^ (72'(3) << 63)); stim_syn.push_back(8'd2);
    test_stream("single_dae", 0, 0);
    n_cmp++;
    if (a_ce_cnt !== 16'd2 || a_due_cnt !== 16'd0 || a_alert !== 1'b0) begin
      n_bad++;
      $display("FAIL single_dae_cnt: got ce=%0d due=%0d alert=%b want 2 0 0", a_ce_cnt, a_due_cnt, a_alert);
    end
  endtask

  task automatic test_te_due();
    do_reset();
    stim_cw.push_back(rnd72() ^ (72'(7) << 69)); stim_syn.push_back(8'd3);
    stim_cw.push_back(rnd72());                  stim_syn.push_back(8'd4);
    stim_cw.push_back(rnd72());                  stim_syn.push_back(8'd5);
    stim_cw.push_back(rnd72());                  stim_syn.push_back(8'd6);
    test_stream("te_due", 0, 0);
    n_cmp++;
    if (a_due_cnt !== 16'd3 || a_ce_cnt !== 16'd1 || a_alert !== 1'b1) begin
      n_bad++;
      $display("FAIL te_due_cnt: got ce=%0d due=%0d alert=%b want 1 3 1", a_ce_cnt, a_due_cnt, a_alert);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      stim_cw.push_back(rnd72());
      stim_syn.push_back(8'($urandom_range(0, 6)));
    end
    test_stream("back_to_back", 1, 0);
  endtask

  task automatic test_threshold();
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      stim_cw.push_back(rnd72()); stim_syn.push_back(8'd1);
    end
    test_stream("threshold", 0, 0);
    n_cmp++;
    if (a_ce_cnt !== 16'd4 || a_alert !== 1'b1 || b_ce_cnt !== 2'd3 || b_alert !== 1'b1) begin
      n_bad++;
      $display("FAIL threshold_end: got a=%0d/%b b=%0d/%b want 4/1 3/1", a_ce_cnt, a_alert, b_ce_cnt, b_alert);
    end
    @(negedge clk);
    out_ready = 1'b0; in_cw = rnd72(); in_syn = 8'd1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!exp_ov() && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (a_out_valid !== 1'b1 || k >= 10) begin
      n_bad++;
      $display("FAIL clr_stall: got out_valid=%b want 1", a_out_valid);
    end
    stat_clr = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    n_cmp++;
    if (a_ce_cnt !== 16'd0 || a_alert !== 1'b0 || b_ce_cnt !== 2'd0 || b_alert !== 1'b0 || a_out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_override: got a=%0d/%b b=%0d/%b v=%b want 0/0 0/0 v=0",
               a_ce_cnt, a_alert, b_ce_cnt, b_alert, a_out_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      stim_cw.push_back(rnd72()); stim_syn.push_back(8'd1);
    end
    test_stream("saturation", 0, 0);
    n_cmp++;
    if (b_ce_cnt !== 2'd3 || a_ce_cnt !== 16'd5) begin
      n_bad++;
      $display("FAIL saturation: got b=%0d a=%0d want 3 5", b_ce_cnt, a_ce_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      stim_cw.push_back(rnd72());
      stim_syn.push_back(8'($urandom_range(0, 255)));
    end
    test_stream("random", 2, 3);
  endtask

  task automatic test_reset_inflight();
    do_reset();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_cw = rnd72(); in_syn = 8'd1;
    @(negedge clk);
    in_cw = rnd72();
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (a_out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL inflight_pre: got out_valid=%b want 1", a_out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_ce_cnt !== 16'd0 || b_ce_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL inflight_rst: got v=%b%b ce=%0d/%0d want v=00 ce=0/0", a_out_valid, b_out_valid, a_ce_cnt, b_ce_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_ce_cnt !== 16'd0 || a_due_cnt !== 16'd0) begin
        n_bad++;
        $display("FAIL inflight_after: got v=%b ce=%0d due=%0d want 0 0 0", a_out_valid, a_ce_cnt, a_due_cnt);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tab_type[i] = 3'($urandom_range(0, 7));
      tab_addr[i] = 7'($urandom_range(0, 127));
    end
    tab_type[0] = 3'b000; tab_addr[0] = 7'd0;
    tab_type[1] = 3'b001; tab_addr[1] = 7'd5;
    tab_type[2] = 3'b010; tab_addr[2] = 7'd63;
    tab_type[3] = 3'b100; tab_addr[3] = 7'd69;
    tab_type[4] = 3'b111; tab_addr[4] = 7'd0;
    tab_type[5] = 3'b001; tab_addr[5] = 7'd72;
    tab_type[6] = 3'b100; tab_addr[6] = 7'd70;
    test_reset();
    test_clean();
    test_single_dae();
    test_te_due();
    test_back_to_back();
    test_threshold();
    test_saturation();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
